bit_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder: sum = a + b + cin, computed LSB-first one bit per clock.
//  The single-bit full-adder cell sits on the datapath; the carry is registered between bits.

---
 rtl/bit_serial_adder_pkg.sv | 10 +
 rtl/bit_serial_adder_fa_1bit.sv | 16 +
 rtl/bit_serial_adder.sv | 109 ++++++++++
 tb/tb_bit_serial_adder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
// 2'd3 is not a legal state; the FSM steers it back to IDLE.
package bit_serial_adder_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_ILLEGAL = 2'd3;

endpackage

// File: rtl/bit_serial_adder_fa_1bit.sv
// Single-bit full-adder cell used on the LSB datapath of the bit-serial adder.
module fa_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and carry of one bit position.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle WIDTH-bit adder: {cout, sum} = a + b + cin, one bit per clock,
// LSB first, through a single full-adder cell with a registered carry.
//
// Handshake: start is sampled only while the FSM is in IDLE or DONE; an
// accepted start captures a/b/cin on that edge. busy is high for the WIDTH
// cycles of the SHIFT phase, done is a one-cycle pulse when sum/cout are
// fresh. Start seen during SHIFT is ignored. Holding start high across DONE
// chains the next add with no idle cycle. sum/cout hold their value until the
// next completion. rst wins over everything, including start.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       state_dbg
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_s;
    logic             fa_co;

    // The one full-adder cell works on the current LSBs and the stored carry.
    fa_1bit u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    // FSM, operand/result shift registers, carry and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {fa_s, res_sr[WIDTH-1:1]};
                    carry  <= fa_co;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        sum   <= {fa_s, res_sr[WIDTH-1:1]};
                        cout  <= fa_co;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        busy      = (state == ST_SHIFT);
        done      = (state == ST_DONE);
        state_dbg = state;
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder: an 8-bit instance for vectors and
// multi-cycle corner cases, a 4-bit instance for an exhaustive sweep.
module tb_bit_serial_adder;
    import bit_serial_adder_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic [1:0] st8;

    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;
    logic [1:0] st4;

    bit_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .state_dbg(st8)
    );

    bit_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .state_dbg(st4)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [7:0] last_sum;
    logic       last_cout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs[7];

    // ---------------- driver tasks ----------------
    // One full 8-bit add with cycle-exact busy/done/hold checks.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] es, input logic ec, input string tag);
        int busy_cnt;
        int done_cnt;
        int hold_bad;
        busy_cnt = 0;
        done_cnt = 0;
        hold_bad = 0;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom()); b8 = 8'($urandom()); cin8 = 1'($urandom());
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            busy_cnt += int'(busy8);
            done_cnt += int'(done8);
            if (sum8 !== last_sum || cout8 !== last_cout) hold_bad++;
        end
        check({tag, "_busy_len"}, 32'(busy_cnt), 32'd8);
        check({tag, "_early_done"}, 32'(done_cnt), 32'd0);
        check({tag, "_sum_hold"}, 32'(hold_bad), 32'd0);
        @(posedge clk); #1;
        check({tag, "_done"}, 32'(done8), 32'd1);
        check({tag, "_busy_end"}, 32'(busy8), 32'd0);
        check({tag, "_sum"}, 32'(sum8), 32'(es));
        check({tag, "_cout"}, 32'(cout8), 32'(ec));
        last_sum = es;
        last_cout = ec;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done8), 32'd0);
        check({tag, "_idle"}, 32'(st8), 32'(ST_IDLE));
    endtask

    // One 4-bit add against the arithmetic model.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [4:0] exp_v;
        bit found;
        found = 1'b0;
        exp_v = 5'(a) + 5'(b) + 5'(cin);
        @(negedge clk);
        a4 = a; b4 = b; cin4 = cin; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            @(posedge clk); #1;
            if (done4) found = 1'b1;
        end
        if (!found) begin
            check($sformatf("w4_timeout_%0h_%0h_%0d", a, b, cin), 32'd0, 32'd1);
        end else if ({cout4, sum4} !== exp_v) begin
            check($sformatf("w4_%0h_%0h_%0d", a, b, cin), 32'({cout4, sum4}), 32'(exp_v));
        end else begin
            checks++;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int done_cnt;
        int done_at;
        logic [7:0] got_sum;
        logic       got_cout;
        int e_cyc;
        int prev_cyc;
        bit found;
        logic [7:0] ha[3];
        logic [7:0] hb[3];
        logic       hc[3];
        logic [7:0] hs[3];
        logic       ho[3];

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{8'h5A, 8'h25, 1'b1, 8'h80, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        last_sum = 8'h00;
        last_cout = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        check("rst_state", 32'(st8), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 7; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
                 $sformatf("vec%0d", i));
        end

        // Start with new operands mid-SHIFT must be ignored.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("mid_busy", 32'(busy8), 32'd1);
        done_cnt = 0; done_at = 0; got_sum = 8'h00; got_cout = 1'b0;
        for (int k = 5; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                done_cnt++;
                done_at = k;
                got_sum = sum8;
                got_cout = cout8;
            end
        end
        check("mid_done_count", 32'(done_cnt), 32'd1);
        check("mid_done_at", 32'(done_at), 32'd8);
        check("mid_sum", 32'(got_sum), 32'h46);
        check("mid_cout", 32'(got_cout), 32'd0);
        last_sum = 8'h46;
        last_cout = 1'b0;

        // Reset three cycles into SHIFT aborts with no done.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(busy8), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_sum", 32'(sum8), 32'd0);
        check("abort_cout", 32'(cout8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            done_cnt += int'(done8);
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        last_sum = 8'h00;
        last_cout = 1'b0;
        run8(8'h5A, 8'h25, 1'b1, 8'h80, 1'b0, "after_abort");

        // Start held high: back-to-back adds chained through DONE.
        ha[0] = 8'h12; hb[0] = 8'h34; hc[0] = 1'b0; hs[0] = 8'h46; ho[0] = 1'b0;
        ha[1] = 8'hFF; hb[1] = 8'h01; hc[1] = 1'b0; hs[1] = 8'h00; ho[1] = 1'b1;
        ha[2] = 8'h5A; hb[2] = 8'h25; hc[2] = 1'b1; hs[2] = 8'h80; ho[2] = 1'b0;
        @(negedge clk);
        a8 = ha[0]; b8 = hb[0]; cin8 = hc[0]; start8 = 1'b1;
        @(posedge clk); #1;
        e_cyc = cyc;
        prev_cyc = cyc;
        for (int i = 0; i < 3; i++) begin
            found = 1'b0;
            for (int t = 0; t < 20 && !found; t++) begin
                @(posedge clk); #1;
                if (done8) found = 1'b1;
            end
            check($sformatf("held%0d_found", i), 32'(found), 32'd1);
            check($sformatf("held%0d_sum", i), 32'(sum8), 32'(hs[i]));
            check($sformatf("held%0d_cout", i), 32'(cout8), 32'(ho[i]));
            if (i == 0) check("held0_latency", 32'(cyc - e_cyc), 32'd8);
            else check($sformatf("held%0d_period", i), 32'(cyc - prev_cyc), 32'd9);
            prev_cyc = cyc;
            if (i < 2) begin
                a8 = ha[i+1]; b8 = hb[i+1]; cin8 = hc[i+1];
            end else begin
                start8 = 1'b0;
            end
        end
        @(posedge clk); #1;
        check("held_end_idle", 32'(st8), 32'(ST_IDLE));

        // Exhaustive 4-bit sweep.
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int cv = 0; cv < 2; cv++) begin
                    run4(4'(av), 4'(bv), 1'(cv));
                end
            end
        end

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
